cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among four execution-side producers: integer, multiply, divide and load/store.
- The bus drives the 48x32 physical register file write port (cdb_w_en/cdb_w_addr/cdb_din) and the ROB/issue-queue wakeup tag.
- Each producer has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter selects one buffered result per cycle into a registered broadcast stage.

Parameters:
- NUM_REQ, 4, number of producers; index 0=int, 1=mult, 2=div, 3=lsq.
- PRF_ADDR_WIDTH, 6, physical register address width (48 entries; $0 is hardwired to zero).
- DATA_WIDTH, 32, result data width.
- ROB_TAG_WIDTH, 5, ROB entry tag width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all pending and broadcasting results.
- req_valid  in  NUM_REQ  producer i presents a result.
- req_ready  out  NUM_REQ  producer i's result is accepted this cycle.
- req_dest_en  in  NUM_REQ  result writes a register (0 for store/branch).
- req_prf_addr  in  NUM_REQ*PRF_ADDR_WIDTH  destination physical register, slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  result data, slice i.
- req_rob_tag  in  NUM_REQ*ROB_TAG_WIDTH  ROB tag, slice i.
- cdb_valid  out  1  broadcast valid (ROB completion).
- cdb_w_en  out  1  PRF write enable.
- cdb_w_addr  out  PRF_ADDR_WIDTH  PRF write address.
- cdb_din  out  DATA_WIDTH  PRF write data.
- cdb_rob_tag  out  ROB_TAG_WIDTH  completing ROB tag.
- cdb_src  out  2  index of the producer broadcasting.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset: buf_valid all 0, rr_ptr=0, cdb_valid=0, cdb_w_en=0, cdb_w_addr=0, cdb_din=0, cdb_rob_tag=0, cdb_src=0.
- Reset mid-operation discards all buffered and broadcasting results.
- Handshake:
  - req_ready[i] = !flush && (!buf_valid[i] || grant[i]).
  - req_ready must not depend on req_valid.
  - A transfer occurs when req_valid[i] && req_ready[i]; buf[i] loads {dest_en, addr, data, tag} at the clock edge.
- Simultaneous drain and load of the same buffer in one cycle is legal. This gives full throughput of one result per cycle per producer when that producer is uncontested.
- Arbitration:
  - Combinational grant among buf_valid, searching from rr_ptr upward with wrap at NUM_REQ-1 to 0.
  - On any grant, rr_ptr <= (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Broadcast register:
  - On grant, the winner's fields load into the cdb_* registers with cdb_valid=1 and cdb_src=winner.
  - With no grant, cdb_valid=0 and cdb_w_en=0; data fields hold.
- cdb_w_en = granted dest_en && (addr != 0). cdb_valid is still 1 for addr 0 or dest_en=0, so the ROB still completes.
- Latency: accepted at edge N, arbitrated in cycle N+1, visible on cdb_* in cycle N+2. There is no combinational path from req_* to cdb_*.
- Fairness: any buffered entry is granted within NUM_REQ cycles of becoming buffered.
- Flush:
  - In the flush cycle: req_ready=0, no grant; next cycle buf_valid=0 and cdb_valid=0, cdb_w_en=0.
  - rr_ptr is unchanged.
  - Flush together with reset behaves as reset.
- The arbiter does not check PRF forwarding. The PRF forwards cdb_din to same-cycle readers itself.

Decomposition:
- Shared package cdb_pkg:
  - Width constants PRF_ADDR_WIDTH, DATA_WIDTH, ROB_TAG_WIDTH.
  - Producer index constants CDB_INT=0, CDB_MULT=1, CDB_DIV=2, CDB_LSQ=3.
  - The packed cdb_entry struct {dest_en, addr, data, tag}.
- One sub-module, rr_arbiter: purely combinational rotating-priority one-hot grant with inputs req[NUM_REQ] and ptr. It is reusable by the issue-queue selectors.
- Buffers and rr_ptr live in cdb_arbiter.

Test Plan:
- Reset, then single producer: int valid at cycle 1 with addr=5, data=0xDEADBEEF, tag=3, dest_en=1. In cycle 3 expect cdb_valid=1, cdb_w_en=1, cdb_w_addr=5, cdb_din=0xDEADBEEF, cdb_rob_tag=3, cdb_src=0. req_ready stays 1 throughout.
- All four producers valid in the same cycle with rr_ptr=0: broadcasts in consecutive cycles in src order 0,1,2,3. req_ready[3] is 0 for cycles 2–4 while buffer 3 waits. Afterwards rr_ptr=0.
- Streaming: mult valid every cycle for 8 results (tags 0–7) with other producers idle. Eight back-to-back cdb_valid cycles with tags 0–7 in order, and req_ready[1] never drops.
- Fairness: int and lsq hold req_valid continuously for 10 cycles. The cdb_src sequence alternates 0,3,0,3,… and no source is granted twice in a row.
- Address 0 / no-destination: div result addr=0, and a separate lsq store with dest_en=0. Both produce cdb_valid=1 with cdb_w_en=0.
- Flush: int and div are buffered and mult is on the bus when flush=1. Next cycle cdb_valid=0 and all buffers are empty. req_ready=0 during the flush cycle, and a new int result after flush broadcasts with 2-cycle latency.

Source files
------------

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_pkg
// Brief    : Shared widths, producer indices and the buffered-result record
//            for the common data bus.
// Revision : 1.0
// ============================================================================
package cdb_pkg;

    localparam int NUM_REQ        = 4;
    localparam int PRF_ADDR_WIDTH = 6;
    localparam int DATA_WIDTH     = 32;
    localparam int ROB_TAG_WIDTH  = 5;

    localparam int CDB_INT  = 0;
    localparam int CDB_MULT = 1;
    localparam int CDB_DIV  = 2;
    localparam int CDB_LSQ  = 3;

    typedef struct packed {
        logic                      dest_en;
        logic [PRF_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [ROB_TAG_WIDTH-1:0]  tag;
    } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority arbiter; one-hot grant to the
//            first requester at or above ptr, wrapping to index 0.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 any_grant
);

    int w_idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                any_grant    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : One-entry holding buffer per producer, round-robin selection and
//            a registered broadcast stage driving the PRF write port and ROB.
// Revision : 1.0
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ        = cdb_pkg::NUM_REQ,
    parameter int PRF_ADDR_WIDTH = cdb_pkg::PRF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = cdb_pkg::DATA_WIDTH,
    parameter int ROB_TAG_WIDTH  = cdb_pkg::ROB_TAG_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_dest_en,
    input  logic [NUM_REQ*PRF_ADDR_WIDTH-1:0] req_prf_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*ROB_TAG_WIDTH-1:0]  req_rob_tag,
    output logic                              cdb_valid,
    output logic                              cdb_w_en,
    output logic [PRF_ADDR_WIDTH-1:0]         cdb_w_addr,
    output logic [DATA_WIDTH-1:0]             cdb_din,
    output logic [ROB_TAG_WIDTH-1:0]          cdb_rob_tag,
    output logic [1:0]                        cdb_src
);

    localparam int c_ptr_width = $clog2(NUM_REQ);

    cdb_entry_t                r_buf [NUM_REQ];
    logic [NUM_REQ-1:0]        r_buf_valid;
    logic [c_ptr_width-1:0]    r_rr_ptr;

    logic                      r_cdb_valid;
    logic                      r_cdb_w_en;
    logic [PRF_ADDR_WIDTH-1:0] r_cdb_addr;
    logic [DATA_WIDTH-1:0]     r_cdb_data;
    logic [ROB_TAG_WIDTH-1:0]  r_cdb_tag;
    logic [1:0]                r_cdb_src;

    cdb_entry_t                w_in [NUM_REQ];
    logic [NUM_REQ-1:0]        w_req;
    logic [NUM_REQ-1:0]        w_grant;
    logic                      w_any_grant;
    logic [c_ptr_width-1:0]    w_winner;
    logic [c_ptr_width-1:0]    w_next_ptr;
    cdb_entry_t                w_win_entry;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
            assign w_in[gi] = {req_dest_en[gi],
                               req_prf_addr[gi*PRF_ADDR_WIDTH +: PRF_ADDR_WIDTH],
                               req_data[gi*DATA_WIDTH +: DATA_WIDTH],
                               req_rob_tag[gi*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]};
        end
    endgenerate

    // Flush masks arbitration so nothing reaches the bus in the squash cycle.
    assign w_req     = r_buf_valid & {NUM_REQ{~flush}};
    assign req_ready = {NUM_REQ{~flush}} & (~r_buf_valid | w_grant);

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (c_ptr_width)
    ) u_rr_arbiter (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .any_grant (w_any_grant)
    );

    always_comb begin
        w_winner    = '0;
        w_win_entry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_winner    = c_ptr_width'(i);
                w_win_entry = r_buf[i];
            end
        end
    end

    assign w_next_ptr = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_w_en  <= 1'b0;
            r_cdb_addr  <= '0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
            r_cdb_src   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    r_buf_valid[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf[i]       <= w_in[i];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end

            if (w_any_grant) begin
                r_rr_ptr    <= w_next_ptr;
                r_cdb_valid <= 1'b1;
                // Register $0 is hardwired; the ROB still sees the completion.
                r_cdb_w_en  <= w_win_entry.dest_en && (w_win_entry.addr != '0);
                r_cdb_addr  <= w_win_entry.addr;
                r_cdb_data  <= w_win_entry.data;
                r_cdb_tag   <= w_win_entry.tag;
                r_cdb_src   <= 2'(w_winner);
            end else begin
                r_cdb_valid <= 1'b0;
                r_cdb_w_en  <= 1'b0;
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_w_en    = r_cdb_w_en;
    assign cdb_w_addr  = r_cdb_addr;
    assign cdb_din     = r_cdb_data;
    assign cdb_rob_tag = r_cdb_tag;
    assign cdb_src     = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed table-driven and sequence checks for cdb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_dest_en;
    logic [N*AW-1:0] req_prf_addr;
    logic [N*DW-1:0] req_data;
    logic [N*TW-1:0] req_rob_tag;
    logic            cdb_valid;
    logic            cdb_w_en;
    logic [AW-1:0]   cdb_w_addr;
    logic [DW-1:0]   cdb_din;
    logic [TW-1:0]   cdb_rob_tag;
    logic [1:0]      cdb_src;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dest_en  (req_dest_en),
        .req_prf_addr (req_prf_addr),
        .req_data     (req_data),
        .req_rob_tag  (req_rob_tag),
        .cdb_valid    (cdb_valid),
        .cdb_w_en     (cdb_w_en),
        .cdb_w_addr   (cdb_w_addr),
        .cdb_din      (cdb_din),
        .cdb_rob_tag  (cdb_rob_tag),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0]    valid;
        logic [N-1:0]    dest_en;
        logic [N*AW-1:0] addr;
        logic [N*TW-1:0] tag;
        logic [N-1:0]    ready;
        logic            cv;
        logic            we;
        logic [AW-1:0]   waddr;
        logic [TW-1:0]   rtag;
        logic [1:0]      src;
    } vec_t;

    vec_t tv [17];

    function automatic logic [31:0] data_of(input int src, input logic [4:0] tag);
        return {8'hC0 + 8'(src), 16'h5A5A, 3'b000, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_cdb(input string name, input logic v, input logic we,
                           input logic [5:0] a, input logic [31:0] d,
                           input logic [4:0] t, input logic [1:0] s);
        chk({name, ".cdb_valid"}, 32'(cdb_valid), 32'(v));
        chk({name, ".cdb_w_en"}, 32'(cdb_w_en), 32'(we));
        if (v) begin
            chk({name, ".cdb_w_addr"}, 32'(cdb_w_addr), 32'(a));
            chk({name, ".cdb_din"}, cdb_din, d);
            chk({name, ".cdb_rob_tag"}, 32'(cdb_rob_tag), 32'(t));
            chk({name, ".cdb_src"}, 32'(cdb_src), 32'(s));
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        req_valid    = '0;
        req_dest_en  = '0;
        req_prf_addr = '0;
        req_data     = '0;
        req_rob_tag  = '0;
    endtask

    task automatic set_req(input int i, input logic de, input logic [5:0] a,
                           input logic [31:0] d, input logic [4:0] t);
        req_valid[i]              = 1'b1;
        req_dest_en[i]            = de;
        req_prf_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]      = d;
        req_rob_tag[i*TW +: TW]   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // all four at once, then addr0/no-dest, then rr_ptr-returned-to-0 probe
        tv[0]  = '{4'b1111, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, {5'd3, 5'd2, 5'd1, 5'd0},
                   4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[1]  = '{4'b0000, 4'b0000, '0, '0, 4'b0001, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[2]  = '{4'b0000, 4'b0000, '0, '0, 4'b0011, 1'b1, 1'b1, 6'd10, 5'd0, 2'd0};
        tv[3]  = '{4'b0000, 4'b0000, '0, '0, 4'b0111, 1'b1, 1'b1, 6'd11, 5'd1, 2'd1};
        tv[4]  = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b1, 6'd12, 5'd2, 2'd2};
        tv[5]  = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b1, 6'd13, 5'd3, 2'd3};
        tv[6]  = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[7]  = '{4'b1100, 4'b0100, {6'd20, 6'd0, 6'd0, 6'd0}, {5'd5, 5'd4, 5'd0, 5'd0},
                   4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[8]  = '{4'b0000, 4'b0000, '0, '0, 4'b0111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[9]  = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b0, 6'd0, 5'd4, 2'd2};
        tv[10] = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b0, 6'd20, 5'd5, 2'd3};
        tv[11] = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[12] = '{4'b0011, 4'b0011, {6'd0, 6'd0, 6'd31, 6'd30}, {5'd0, 5'd0, 5'd7, 5'd6},
                   4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[13] = '{4'b0000, 4'b0000, '0, '0, 4'b1101, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};
        tv[14] = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b1, 6'd30, 5'd6, 2'd0};
        tv[15] = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b1, 1'b1, 6'd31, 5'd7, 2'd1};
        tv[16] = '{4'b0000, 4'b0000, '0, '0, 4'b1111, 1'b0, 1'b0, 6'd0, 5'd0, 2'd0};

        do_reset();
        chk("reset.req_ready", 32'(req_ready), 32'hF);
        chk("reset.cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset.cdb_w_en", 32'(cdb_w_en), 32'd0);
        chk("reset.cdb_w_addr", 32'(cdb_w_addr), 32'd0);
        chk("reset.cdb_din", cdb_din, 32'd0);
        chk("reset.cdb_rob_tag", 32'(cdb_rob_tag), 32'd0);
        chk("reset.cdb_src", 32'(cdb_src), 32'd0);

        for (int r = 0; r < 17; r++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                if (tv[r].valid[i])
                    set_req(i, tv[r].dest_en[i], tv[r].addr[i*AW +: AW],
                            data_of(i, tv[r].tag[i*TW +: TW]), tv[r].tag[i*TW +: TW]);
            end
            #1;
            chk($sformatf("vec%0d.req_ready", r), 32'(req_ready), 32'(tv[r].ready));
            chk_cdb($sformatf("vec%0d", r), tv[r].cv, tv[r].we, tv[r].waddr,
                    data_of(int'(tv[r].src), tv[r].rtag), tv[r].rtag, tv[r].src);
        end

        // single int producer, two-cycle latency
        do_reset();
        tick(); idle(); set_req(CDB_INT, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3); #1;
        chk("single.c1.ready", 32'(req_ready[0]), 32'd1);
        chk("single.c1.cdb_valid", 32'(cdb_valid), 32'd0);
        tick(); idle(); #1;
        chk("single.c2.ready", 32'(req_ready[0]), 32'd1);
        chk("single.c2.cdb_valid", 32'(cdb_valid), 32'd0);
        tick(); #1;
        chk("single.c3.ready", 32'(req_ready[0]), 32'd1);
        chk_cdb("single.c3", 1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3, 2'd0);
        tick(); #1;
        chk("single.c4.cdb_valid", 32'(cdb_valid), 32'd0);

        // mult streaming one result per cycle
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            tick(); idle();
            if (c <= 8)
                set_req(CDB_MULT, 1'b1, 6'(c + 7), data_of(1, 5'(c - 1)), 5'(c - 1));
            #1;
            chk($sformatf("stream.c%0d.ready", c), 32'(req_ready[1]), 32'd1);
            if (c >= 3 && c <= 10)
                chk_cdb($sformatf("stream.c%0d", c), 1'b1, 1'b1, 6'(c + 5),
                        data_of(1, 5'(c - 3)), 5'(c - 3), 2'd1);
            else
                chk($sformatf("stream.c%0d.cdb_valid", c), 32'(cdb_valid), 32'd0);
        end

        // int and lsq contend continuously
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            tick(); idle();
            if (c <= 10) begin
                set_req(CDB_INT, 1'b1, 6'd40, data_of(0, 5'(c)), 5'(c));
                set_req(CDB_LSQ, 1'b1, 6'd41, data_of(3, 5'(c)), 5'(c));
            end
            #1;
            if (c >= 3 && c <= 11) begin
                chk($sformatf("fair.c%0d.cdb_valid", c), 32'(cdb_valid), 32'd1);
                chk($sformatf("fair.c%0d.cdb_src", c), 32'(cdb_src),
                    (c % 2 == 1) ? 32'd0 : 32'd3);
            end
        end

        // flush with int/div buffered and mult broadcasting
        do_reset();
        tick(); idle(); set_req(CDB_MULT, 1'b1, 6'd7, data_of(1, 5'd1), 5'd1); #1;
        tick(); idle();
        set_req(CDB_INT, 1'b1, 6'd8, data_of(0, 5'd2), 5'd2);
        set_req(CDB_DIV, 1'b1, 6'd9, data_of(2, 5'd3), 5'd3);
        #1;
        tick(); idle(); flush = 1'b1;
        set_req(CDB_INT, 1'b1, 6'd10, data_of(0, 5'd4), 5'd4);
        #1;
        chk("flush.c3.req_ready", 32'(req_ready), 32'd0);
        chk_cdb("flush.c3", 1'b1, 1'b1, 6'd7, data_of(1, 5'd1), 5'd1, 2'd1);
        tick(); idle(); set_req(CDB_INT, 1'b1, 6'd11, data_of(0, 5'd9), 5'd9); #1;
        chk_cdb("flush.c4", 1'b0, 1'b0, 6'd0, 32'd0, 5'd0, 2'd0);
        chk("flush.c4.req_ready", 32'(req_ready), 32'hF);
        tick(); idle(); #1;
        chk("flush.c5.cdb_valid", 32'(cdb_valid), 32'd0);
        tick(); #1;
        chk_cdb("flush.c6", 1'b1, 1'b1, 6'd11, data_of(0, 5'd9), 5'd9, 2'd0);
        tick(); #1;
        chk("flush.c7.cdb_valid", 32'(cdb_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
